// File: rtl/bus_txn_pkg.sv
// bus_txn_pkg: shared transaction type and round-robin winner search for the bus concentrator
package bus_txn_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 32;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } txn_t;
  // Unused upper request bits are zero, so a modulo-16 search equals a modulo-NCH search.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last);
    logic [3:0] idx;
    rr_next = last;
    for (int i = 16; i >= 1; i--) begin
      idx = last + 4'(i);
      if (req[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/txn_fifo.sv
// txn_fifo: synchronous FIFO with registered occupancy count; a full FIFO ignores push
module txn_fifo
  import bus_txn_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/bus_rr_txn_mux.sv
// bus_rr_txn_mux: per-channel FIFOs drained round-robin into one registered valid/ready bus
module bus_rr_txn_mux
  import bus_txn_pkg::*;
#(
  parameter int NCH = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH*ADDR_W-1:0] in_addr,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [DATA_W-1:0]     out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic [NCH-1:0]        fifo_full
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W+DATA_W-1:0] head [NCH];
  logic [CW-1:0] cnt [NCH];
  logic [NCH-1:0] empty, req, pop;
  logic [CH_W-1:0] rr_ptr, win;
  logic slot, any;
  assign slot = !out_valid || out_ready;
  assign req = ~empty;
  assign any = |req;
  assign win = CH_W'(rr_next(16'(req), 4'(rr_ptr)));
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      assign in_ready[i] = cnt[i] != CW'(DEPTH);
      assign pop[i] = slot && any && win == CH_W'(i);
      txn_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid[i]),
        .pop   (pop[i]),
        .wdata ({in_addr[i*ADDR_W +: ADDR_W], in_data[i*DATA_W +: DATA_W]}),
        .rdata (head[i]),
        .full  (fifo_full[i]),
        .empty (empty[i]),
        .count (cnt[i])
      );
    end
  endgenerate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      out_ch <= '0;
      rr_ptr <= CH_W'(NCH - 1);
    end else if (slot) begin
      out_valid <= any;
      if (any) begin
        {out_addr, out_data} <= head[win];
        out_ch <= win;
        rr_ptr <= win;
      end
    end
  end
endmodule
